// File: rtl/bias_act_pkg.sv
// bias_act_pkg: shared widths, lane count and saturation limits for bias_act_unit
package bias_act_pkg;
  localparam int LANES = 8;
  localparam int ACC_W = 20;
  localparam int BIAS_W = 8;
  localparam int BIAS_LSH = 4;
  localparam int OUT_W = 8;
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [OUT_W-1:0] SAT_MAX = 8'sd127;
  localparam logic signed [OUT_W-1:0] SAT_MIN = -8'sd128;
endpackage

// File: rtl/bias_act_if.sv
// bias_act_if: accumulator-in / bias-controller / activation-out bundle; slave = bias_act_unit, master = upstream+sink
interface bias_act_if;
  import bias_act_pkg::*;
  logic i_vld;
  logic [LANES*ACC_W-1:0] i_acc;
  logic [4:0] i_shift;
  logic i_relu_en;
  logic o_bias_req;
  logic [LANES*BIAS_W-1:0] i_bias;
  logic o_vld;
  logic [LANES*OUT_W-1:0] o_data;
  logic [3:0] o_grp;
  logic o_last;
  modport slave(input i_vld, i_acc, i_shift, i_relu_en, i_bias, output o_bias_req, o_vld, o_data, o_grp, o_last);
  modport master(output i_vld, i_acc, i_shift, i_relu_en, i_bias, input o_bias_req, o_vld, o_data, o_grp, o_last);
endinterface

// File: rtl/bias_act_lane.sv
// bias_act_lane: one lane of bias add, optional round (BIAS_ACT_ROUND_EN), arithmetic shift, ReLU, saturate; ports acc/bias/shift/relu_en in, act out
module bias_act_lane
  import bias_act_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic [4:0]               shift,
  input  logic                     relu_en,
  output logic signed [OUT_W-1:0]  act
);
  logic signed [SUM_W-1:0] s, t, r, z;
  assign s = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc} + ({{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias} <<< BIAS_LSH);
`ifdef BIAS_ACT_ROUND_EN
  assign t = shift != '0 ? s + (SUM_W'(1) << (shift - 5'd1)) : s;
`else
  assign t = s;
`endif
  assign r = t >>> shift;
  assign z = relu_en && r[SUM_W-1] ? '0 : r;
  assign act = z > SUM_W'(SAT_MAX) ? SAT_MAX : z < SUM_W'(SAT_MIN) ? SAT_MIN : z[OUT_W-1:0];
endmodule

// File: rtl/bias_act_unit.sv
// bias_act_unit: 2-stage bias/round/shift/ReLU/saturate over LANES lanes; ports clk, rst (async high), bus (bias_act_if.slave); rounding via BIAS_ACT_ROUND_EN
module bias_act_unit
  import bias_act_pkg::*;
(
  input logic clk,
  input logic rst,
  bias_act_if.slave bus
);
  logic [3:0] cnt, grp1, grp2;
  logic vld1, vld2, relu1, last2;
  logic [4:0] shift1;
  logic [LANES*ACC_W-1:0] acc1;
  logic [LANES*OUT_W-1:0] act, data2;
  // The controller latches its bias on this strobe and presents it during our stage 1.
  assign bus.o_bias_req = bus.i_vld;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bias_act_lane u_lane (
      .acc(acc1[g*ACC_W +: ACC_W]),
      .bias(bus.i_bias[g*BIAS_W +: BIAS_W]),
      .shift(shift1),
      .relu_en(relu1),
      .act(act[g*OUT_W +: OUT_W])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      grp1 <= '0;
      grp2 <= '0;
      vld1 <= 1'b0;
      vld2 <= 1'b0;
      relu1 <= 1'b0;
      last2 <= 1'b0;
      shift1 <= '0;
      acc1 <= '0;
      data2 <= '0;
    end else begin
      vld1 <= bus.i_vld;
      vld2 <= vld1;
      last2 <= vld1 && grp1 == 4'hf;
      if (bus.i_vld) begin
        acc1 <= bus.i_acc;
        shift1 <= bus.i_shift;
        relu1 <= bus.i_relu_en;
        grp1 <= cnt;
        cnt <= cnt + 4'd1;
      end
      if (vld1) begin
        data2 <= act;
        grp2 <= grp1;
      end
    end
  assign bus.o_vld = vld2;
  assign bus.o_data = data2;
  assign bus.o_grp = grp2;
  assign bus.o_last = last2;
endmodule

// File: tb/tb_bias_act_unit.sv
// tb_bias_act_unit: randomized + directed self-check of bias_act_unit against an arithmetic reference model
module tb_bias_act_unit;
  import bias_act_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  bias_act_if bus();
  bias_act_unit dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [63:0] mem [16];
  logic [3:0] baddr, mgrp, p1g, eg;
  logic p1v, ev, el;
  logic [LANES*OUT_W-1:0] p1d, ed;

  function automatic logic [7:0] lane_model(logic signed [19:0] a, logic signed [7:0] b, int sh, bit relu);
    longint s;
    s = longint'(a) + longint'(b) * 16;
`ifdef BIAS_ACT_ROUND_EN
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
    s = s >>> sh;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic logic [63:0] group_model(logic [159:0] acc, logic [63:0] b, logic [4:0] sh, bit relu);
    logic [63:0] o;
    for (int l = 0; l < LANES; l++) o[l*8 +: 8] = lane_model(acc[l*20 +: 20], b[l*8 +: 8], int'(sh), relu);
    return o;
  endfunction

  // Upstream bias controller: address counter, word returned one cycle after the strobe.
  always @(posedge clk or posedge rst)
    if (rst) baddr <= '0;
    else if (bus.o_bias_req) begin
      bus.i_bias <= mem[baddr];
      baddr <= baddr + 4'd1;
    end

  // Reference: expected outputs two cycles after a beat, data held otherwise.
  always @(posedge clk or posedge rst)
    if (rst) begin
      mgrp <= '0; p1v <= 1'b0; p1g <= '0; p1d <= '0;
      ev <= 1'b0; ed <= '0; eg <= '0; el <= 1'b0;
    end else begin
      p1v <= bus.i_vld;
      if (bus.i_vld) begin
        p1d <= group_model(bus.i_acc, mem[mgrp], bus.i_shift, bus.i_relu_en);
        p1g <= mgrp;
        mgrp <= mgrp + 4'd1;
      end
      ev <= p1v;
      if (p1v) begin
        ed <= p1d; eg <= p1g; el <= (p1g == 4'd15);
      end
    end

  always @(negedge clk) begin
    checks++;
    if (bus.o_vld !== ev) begin errors++; $display("FAIL o_vld: got %b expected %b at %0t", bus.o_vld, ev, $time); end
    checks++;
    if (bus.o_data !== ed) begin errors++; $display("FAIL o_data: got %h expected %h at %0t", bus.o_data, ed, $time); end
    if (ev) begin
      checks++;
      if (bus.o_grp !== eg) begin errors++; $display("FAIL o_grp: got %0d expected %0d at %0t", bus.o_grp, eg, $time); end
      checks++;
      if (bus.o_last !== el) begin errors++; $display("FAIL o_last: got %b expected %b at %0t", bus.o_last, el, $time); end
    end
  end

  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
  endtask

  task automatic fill(logic [63:0] w);
    for (int i = 0; i < 16; i++) mem[i] = w;
  endtask

  task automatic beat0(string n, int acc0, int sh, bit relu, int e);
    @(negedge clk);
    bus.i_vld = 1'b1; bus.i_acc = '0; bus.i_acc[19:0] = 20'(acc0);
    bus.i_shift = 5'(sh); bus.i_relu_en = relu;
    #1 chk({n, " bias_req"}, bus.o_bias_req, 1);
    @(negedge clk);
    bus.i_vld = 1'b0;
    @(negedge clk);
    chk({n, " vld"}, bus.o_vld, 1);
    chk(n, $signed(bus.o_data[7:0]), e);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    bus.i_vld = 1'b0; bus.i_acc = '0; bus.i_shift = '0; bus.i_relu_en = 1'b0;
    fill(64'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle o_vld", bus.o_vld, 0);
    chk("idle o_grp", bus.o_grp, 0);
    chk("idle o_data", bus.o_data, 0);
    chk("idle o_bias_req", bus.o_bias_req, 0);
    chk("idle o_last", bus.o_last, 0);
    fill(64'h2);
    beat0("basic", 100, 2, 0, 33);
    fill(64'h0);
`ifdef BIAS_ACT_ROUND_EN
    beat0("round pos", 6, 2, 0, 2);
    beat0("round neg", -6, 2, 0, -1);
`else
    beat0("trunc pos", 6, 2, 0, 1);
    beat0("trunc neg", -6, 2, 0, -2);
`endif
    beat0("relu", -500, 0, 1, 0);
    beat0("sat low", -500, 0, 0, -128);
    beat0("sat high", 4000, 0, 0, 127);
    beat0("hold check prep", 40, 3, 0, 5);
    @(negedge clk);
    chk("hold o_data", $signed(bus.o_data[7:0]), 5);
    // Framing: 17 back-to-back beats from group 0.
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    do_reset();
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("frame vld", bus.o_vld, 1);
        chk("frame grp", bus.o_grp, (k - 2) % 16);
        chk("frame last", bus.o_last, (k - 2) == 15);
      end
      bus.i_vld = (k < 17);
      bus.i_acc = {$urandom, $urandom, $urandom, $urandom, $urandom};
      bus.i_shift = 5'($urandom_range(0, 20));
      bus.i_relu_en = 1'($urandom);
    end
    bus.i_vld = 1'b0;
    // Reset during the third beat's second stage.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.i_vld = (k < 5);
      bus.i_acc = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (k == 3) #2 rst = 1'b1;
      if (k == 5) #2 rst = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("post-reset quiet", bus.o_vld, 0);
    end
    bus.i_vld = 1'b1;
    @(negedge clk);
    bus.i_vld = 1'b0;
    @(negedge clk);
    chk("post-reset vld", bus.o_vld, 1);
    chk("post-reset grp", bus.o_grp, 0);
    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k % 50 == 0) mem[$urandom_range(0, 15)] = {$urandom, $urandom};
      bus.i_vld = ($urandom_range(0, 9) < 7);
      for (int l = 0; l < LANES; l++)
        bus.i_acc[l*20 +: 20] = $urandom_range(0, 1) ? 20'($urandom) : 20'($signed($urandom_range(0, 4000)) - 2000);
      bus.i_shift = 5'($urandom_range(0, 20));
      bus.i_relu_en = 1'($urandom);
    end
    bus.i_vld = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bias_act_unit.md
# bias_act_unit

Post-accumulation stage for the convolution datapath: takes one group of LANES accumulator results per valid beat, adds the matching per-channel bias, rounds, shifts, optionally applies ReLU and saturates to 8-bit activations. It sits directly downstream of the bias controller. It drives that controller's advance/chip-select strobe and consumes its 64-bit bias word one cycle later. It keeps a mirror of the controller's 4-bit bias address so output groups are tagged and framed.

## Interface
- LANES, 8, channels processed per beat (LANES*BIAS_W must equal 64)
- ACC_W, 20, signed accumulator width per lane
- BIAS_W, 8, signed bias width per lane
- BIAS_LSH, 4, left shift applied to bias before the add (bias scale alignment)
- OUT_W, 8, signed output activation width per lane
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- i_vld  in  1  accumulator group valid
- i_acc  in  LANES*ACC_W  packed signed accumulators, lane 0 in LSBs
- i_shift  in  5  right-shift amount, sampled with i_vld, legal 0..ACC_W
- i_relu_en  in  1  ReLU enable, sampled with i_vld
- o_bias_req  out  1  combinational copy of i_vld; drives bias controller i_vld and i_cs
- i_bias  in  64  packed signed biases from bias controller, valid 1 cycle after o_bias_req
- o_vld  out  1  output group valid
- o_data  out  LANES*OUT_W  packed signed activations, lane 0 in LSBs
- o_grp  out  4  group index of o_data (0..15)
- o_last  out  1  high with o_vld when o_grp==15

## Operation
- Stage 1 (cycle t+1): register i_acc, i_shift, i_relu_en, i_vld, and the group counter value. The bias controller returns i_bias for the same group in this cycle.
- Group counter: 4 bits, reset 0, increments on each i_vld, wraps 15->0. Tracks the controller's bias address exactly; no other clear.
- Stage 2 per lane, combinational from stage-1 regs plus i_bias, then registered:
  - b = sext(bias) << BIAS_LSH
  - s = sext(acc) + b, width ACC_W+2, no overflow possible
  - if shift>0 and rounding is compiled in: s += 1<<(shift-1)
  - r = s >>> shift (arithmetic)
  - if relu_en and r<0: r = 0
  - saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-128, 127]
- i_shift > ACC_W is illegal; the output is then don't-care, but o_vld framing is still correct.
- No backpressure: a beat accepted every cycle i_vld is high, back-to-back allowed.
- System reset must reset this block and the bias controller together. Partial reset desynchronizes the group mirror and is not supported.

## Timing
- Latency i_vld -> o_vld: 2 cycles. o_data, o_grp and o_last are registered and valid only with o_vld.
- o_bias_req has 0 latency (combinational from i_vld).
- Reset values: o_vld=0, o_last=0, o_grp=0, o_data=0, stage-1 valid=0, counter=0.
- Reset asserted mid-stream: in-flight beats are dropped. The first beat after deassertion is group 0.
- o_data holds its last value when o_vld=0.
- Wrap: a beat with counter 15 emits o_grp=15, o_last=1. The next beat emits o_grp=0.

## Configuration
- BIAS_ACT_ROUND_EN defined: round-half-up by adding 1<<(shift-1) before the shift when shift>0.
- Not defined: truncation (plain arithmetic shift, round toward -inf). The rounding adder is removed.

## Structure
- Package bias_act_pkg: ACC_W, BIAS_W, OUT_W, LANES, BIAS_LSH defaults, SUM_W=ACC_W+2, and the saturation min/max constants.
- Sub-module bias_act_lane: one lane's stage-2 arithmetic, covering add, round, shift, ReLU and saturate. It is combinational and instantiated LANES times via generate. The top owns all registers and the counter.

## Test plan
- Reset/idle: rst high then low, no i_vld -> o_vld=0, o_grp=0, o_data=0, o_bias_req=0.
- Basic add: acc lane0=100, bias lane0=2, BIAS_LSH=4, shift=2, relu off -> s=132, o_data lane0=33 two cycles after i_vld.
- Rounding: acc=6, bias=0, shift=2 -> 2 with BIAS_ACT_ROUND_EN, 1 without. acc=-6 -> -1 with, -2 without.
- ReLU and saturation: acc=-500, relu on -> 0. Same beat relu off, shift 0 -> -128. acc=4000, shift 0 -> 127.
- Framing: 17 back-to-back i_vld -> o_grp 0..15, 0. o_last only on the 16th. o_vld continuous for 17 cycles starting 2 cycles after the first i_vld.
- Reset mid-stream: 5 beats, assert rst during beat 3's stage 2 -> no o_vld after reset. The next beat reports o_grp=0.
